// File: rtl/mem_bridge.sv
// -----------------------------------------------------------------------------
// mem_bridge
//
// Purpose:
//   Single-outstanding bridge between two requesting masters (instruction
//   fetch and load/store) and a simple simulation memory model. Arbitrates
//   fairly between the masters, runs one memory transaction at a time, encodes
//   the store size as a byte mask, and returns size-formatted, sign/zero
//   extended read data as a one-cycle response pulse.
//
//   Transaction timing (accept in cycle T):
//     read : T   mem_rd_en/mem_rd_addr driven combinationally
//            T+1 capture and format mem_rd_data
//            T+2 response pulse
//     write: T   register address, masked data and byte mask
//            T+1 mem_we_en high, all write outputs straight from flops
//            T+2 response pulse (rdata = 0)
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   if_req_* / if_rsp_*       fetch request handshake / fetch response pulse
//   ls_req_* / ls_rsp_*       load/store request handshake / completion pulse
//   mem_rd_*                  memory read port (data returns the next cycle)
//   mem_we_*                  memory write port (memory writes while en high)
// -----------------------------------------------------------------------------
module mem_bridge #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_req_addr,
    output logic          if_rsp_valid,
    output logic [31:0]   if_rsp_inst,
    input  logic          ls_req_valid,
    output logic          ls_req_ready,
    input  logic          ls_req_we,
    input  logic [AW-1:0] ls_req_addr,
    input  logic [DW-1:0] ls_req_wdata,
    input  logic [1:0]    ls_req_size,
    input  logic          ls_req_signed,
    output logic          ls_rsp_valid,
    output logic [DW-1:0] ls_rsp_rdata,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          mem_we_en,
    output logic [AW-1:0] mem_we_addr,
    output logic [DW-1:0] mem_we_data,
    output logic [7:0]    mem_we_mask
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    // Byte-mask encoding of the access size expected by the memory model.
    function automatic logic [7:0] size_to_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            2'b11:   mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Clear every store-data byte above the access size.
    function automatic logic [DW-1:0] trim_wdata(input logic [DW-1:0] data,
                                                 input logic [1:0]    size);
        logic [DW-1:0] keep;
        case (size)
            2'b00:   keep = {{(DW-8){1'b0}},  8'hFF};
            2'b01:   keep = {{(DW-16){1'b0}}, 16'hFFFF};
            2'b10:   keep = {{(DW-32){1'b0}}, 32'hFFFF_FFFF};
            2'b11:   keep = {DW{1'b1}};
            default: keep = {DW{1'b1}};
        endcase
        return data & keep;
    endfunction

    // Take the low size bytes of the read word and extend them to DW.
    function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] data,
                                                  input logic [1:0]    size,
                                                  input logic          sgn);
        logic [DW-1:0] res;
        case (size)
            2'b00:   res = {{(DW-8){sgn & data[7]}},   data[7:0]};
            2'b01:   res = {{(DW-16){sgn & data[15]}}, data[15:0]};
            2'b10:   res = {{(DW-32){sgn & data[31]}}, data[31:0]};
            2'b11:   res = data;
            default: res = data;
        endcase
        return res;
    endfunction

    state_t        state_q,        state_d;
    logic          last_grant_q,   last_grant_d;
    logic          is_ls_q,        is_ls_d;
    logic [1:0]    size_q,         size_d;
    logic          signed_q,       signed_d;
    logic          mem_we_en_q,    mem_we_en_d;
    logic [AW-1:0] mem_we_addr_q,  mem_we_addr_d;
    logic [DW-1:0] mem_we_data_q,  mem_we_data_d;
    logic [7:0]    mem_we_mask_q,  mem_we_mask_d;
    logic          if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0]   if_rsp_inst_q,  if_rsp_inst_d;
    logic          ls_rsp_valid_q, ls_rsp_valid_d;
    logic [DW-1:0] ls_rsp_rdata_q, ls_rsp_rdata_d;

    logic          grant_ls_s;
    logic          grant_if_s;

    // Fair arbitration: on a tie the port that did not win last time goes.
    // Gated with rst so nothing is accepted while reset is being applied.
    always_comb begin
        grant_ls_s = rst & ls_req_valid &
                     (~if_req_valid | (last_grant_q == GRANT_IFU));
        grant_if_s = rst & if_req_valid & ~grant_ls_s;
    end

    // Next-state, handshake and memory-port decode.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        is_ls_d        = is_ls_q;
        size_d         = size_q;
        signed_d       = signed_q;
        mem_we_en_d    = 1'b0;
        mem_we_addr_d  = {AW{1'b0}};
        mem_we_data_d  = {DW{1'b0}};
        mem_we_mask_d  = 8'h00;
        if_rsp_valid_d = 1'b0;
        if_rsp_inst_d  = 32'h0000_0000;
        ls_rsp_valid_d = 1'b0;
        ls_rsp_rdata_d = {DW{1'b0}};
        if_req_ready   = 1'b0;
        ls_req_ready   = 1'b0;
        mem_rd_en      = 1'b0;
        mem_rd_addr    = {AW{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (grant_ls_s) begin
                    ls_req_ready = 1'b1;
                    last_grant_d = GRANT_LSU;
                    is_ls_d      = 1'b1;
                    size_d       = ls_req_size;
                    signed_d     = ls_req_signed;
                    if (ls_req_we) begin
                        mem_we_en_d   = 1'b1;
                        mem_we_addr_d = ls_req_addr;
                        mem_we_data_d = trim_wdata(ls_req_wdata, ls_req_size);
                        mem_we_mask_d = size_to_mask(ls_req_size);
                        state_d       = ST_WR;
                    end else begin
                        mem_rd_en   = 1'b1;
                        mem_rd_addr = ls_req_addr;
                        state_d     = ST_RD;
                    end
                end else if (grant_if_s) begin
                    if_req_ready = 1'b1;
                    last_grant_d = GRANT_IFU;
                    is_ls_d      = 1'b0;
                    size_d       = 2'b10;
                    signed_d     = 1'b0;
                    mem_rd_en    = 1'b1;
                    mem_rd_addr  = if_req_addr;
                    state_d      = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (is_ls_q) begin
                    ls_rsp_valid_d = 1'b1;
                    ls_rsp_rdata_d = extend_load(mem_rd_data, size_q, signed_q);
                end else begin
                    if_rsp_valid_d = 1'b1;
                    if_rsp_inst_d  = mem_rd_data[31:0];
                end
                state_d = ST_RSP;
            end
            ST_WR: begin
                // Store completion carries no data.
                ls_rsp_valid_d = 1'b1;
                state_d        = ST_RSP;
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= GRANT_IFU;
            is_ls_q        <= 1'b0;
            size_q         <= 2'b00;
            signed_q       <= 1'b0;
            mem_we_en_q    <= 1'b0;
            mem_we_addr_q  <= {AW{1'b0}};
            mem_we_data_q  <= {DW{1'b0}};
            mem_we_mask_q  <= 8'h00;
            if_rsp_valid_q <= 1'b0;
            if_rsp_inst_q  <= 32'h0000_0000;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_rdata_q <= {DW{1'b0}};
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            is_ls_q        <= is_ls_d;
            size_q         <= size_d;
            signed_q       <= signed_d;
            mem_we_en_q    <= mem_we_en_d;
            mem_we_addr_q  <= mem_we_addr_d;
            mem_we_data_q  <= mem_we_data_d;
            mem_we_mask_q  <= mem_we_mask_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_inst_q  <= if_rsp_inst_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
            ls_rsp_rdata_q <= ls_rsp_rdata_d;
        end
    end

    assign mem_we_en    = mem_we_en_q;
    assign mem_we_addr  = mem_we_addr_q;
    assign mem_we_data  = mem_we_data_q;
    assign mem_we_mask  = mem_we_mask_q;
    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_inst  = if_rsp_inst_q;
    assign ls_rsp_valid = ls_rsp_valid_q;
    assign ls_rsp_rdata = ls_rsp_rdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_mem_bridge
//
// Directed bench for mem_bridge. Drivers push hand-computed expectations
// (response data, response cycle, write beat) into queues at the moment a
// request is accepted; a negedge monitor pops and compares whenever the DUT
// presents a response or a write beat. A small memory model answers reads
// from a fixed address table one cycle after mem_rd_en.
// -----------------------------------------------------------------------------
module tb_mem_bridge;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic        ls_req_we;
    logic [63:0] ls_req_addr;
    logic [63:0] ls_req_wdata;
    logic [1:0]  ls_req_size;
    logic        ls_req_signed;
    logic        ls_rsp_valid;
    logic [63:0] ls_rsp_rdata;
    logic        mem_rd_en;
    logic [63:0] mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic        mem_we_en;
    logic [63:0] mem_we_addr;
    logic [63:0] mem_we_data;
    logic [7:0]  mem_we_mask;

    mem_bridge #(.AW(64), .DW(64)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_inst(if_rsp_inst),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
        .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
        .ls_req_wdata(ls_req_wdata), .ls_req_size(ls_req_size),
        .ls_req_signed(ls_req_signed),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .mem_we_en(mem_we_en), .mem_we_addr(mem_we_addr),
        .mem_we_data(mem_we_data), .mem_we_mask(mem_we_mask)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
        int          cyc;
    } wr_exp_t;

    rsp_exp_t if_q[$];
    rsp_exp_t ls_q[$];
    wr_exp_t  wr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle counter: value during a cycle is the index of that cycle
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // memory contents used by the directed vectors
    function automatic logic [63:0] mem_val(input logic [63:0] a);
        case (a)
            64'h8000_0008: return 64'h0000_0000_8000_0001;
            64'h8000_0000: return 64'h1111_2222_0010_0513;
            64'h8000_0020: return 64'h1234_5678_9ABC_DEF0;
            64'h8000_0040: return 64'hAAAA_BBBB_0000_0013;
            64'h8000_0044: return 64'h0000_0000_FFFF_FFFF;
            64'h8000_0048: return 64'h0123_4567_89AB_CDEF;
            64'h8000_0100: return 64'h0000_0000_0000_8001;
            64'h8000_0110: return 64'hFEDC_BA98_7654_3210;
            default:       return 64'h0;
        endcase
    endfunction

    // read data appears the cycle after mem_rd_en is sampled
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_val(mem_rd_addr) : 64'h0;

    // monitor: pops expectations whenever the DUT produces a response/write
    always @(negedge clk) begin
        rsp_exp_t e;
        wr_exp_t  w;
        if (if_rsp_valid) begin
            if (if_q.size() == 0) begin
                check("if_rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = if_q.pop_front();
                check("if_rsp_inst", {32'h0, if_rsp_inst}, e.data);
                check("if_rsp_latency", 64'(cyc), 64'(e.cyc + 2));
            end
        end
        if (ls_rsp_valid) begin
            if (ls_q.size() == 0) begin
                check("ls_rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = ls_q.pop_front();
                check("ls_rsp_rdata", ls_rsp_rdata, e.data);
                check("ls_rsp_latency", 64'(cyc), 64'(e.cyc + 2));
            end
        end
        if (if_rsp_valid && ls_rsp_valid)
            check("both_rsp_pulse", 64'd1, 64'd0);
        if (mem_we_en) begin
            if (wr_q.size() == 0) begin
                check("mem_we_unexpected", 64'd1, 64'd0);
            end else begin
                w = wr_q.pop_front();
                check("mem_we_addr", mem_we_addr, w.addr);
                check("mem_we_data", mem_we_data, w.data);
                check("mem_we_mask", {56'h0, mem_we_mask}, {56'h0, w.mask});
                check("mem_we_cycle", 64'(cyc), 64'(w.cyc + 1));
            end
        end else begin
            check("mem_we_idle_zero", mem_we_addr | mem_we_data | {56'h0, mem_we_mask}, 64'h0);
        end
        if (!mem_rd_en) check("mem_rd_idle_zero", mem_rd_addr, 64'h0);
    end

    task automatic idle_inputs();
        if_req_valid  = 1'b0;
        if_req_addr   = 64'h0;
        ls_req_valid  = 1'b0;
        ls_req_we     = 1'b0;
        ls_req_addr   = 64'h0;
        ls_req_wdata  = 64'h0;
        ls_req_size   = 2'b00;
        ls_req_signed = 1'b0;
    endtask

    // every DUT output must read zero
    task automatic check_all_zero(input string name);
        check(name, {56'h0, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                     mem_rd_en, mem_we_en, 2'b00} |
                    {32'h0, if_rsp_inst} | ls_rsp_rdata | mem_rd_addr |
                    mem_we_addr | mem_we_data | {56'h0, mem_we_mask}, 64'h0);
    endtask

    // Issue one request on one port; push expectations when it is accepted.
    task automatic issue(input bit is_ls, input bit we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [1:0] size,
                         input bit sgn, input bit exp_rsp,
                         input logic [63:0] exp_data,
                         input logic [63:0] exp_wdata, input logic [7:0] exp_mask);
        bit done = 1'b0;
        if (is_ls) begin
            ls_req_valid = 1'b1; ls_req_we = we; ls_req_addr = addr;
            ls_req_wdata = wdata; ls_req_size = size; ls_req_signed = sgn;
        end else begin
            if_req_valid = 1'b1; if_req_addr = addr;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (is_ls ? ls_req_ready : if_req_ready) begin
                done = 1'b1;
                if (exp_rsp) begin
                    if (is_ls) ls_q.push_back('{exp_data, cyc});
                    else       if_q.push_back('{exp_data, cyc});
                end
                if (we) wr_q.push_back('{addr, exp_wdata, exp_mask, cyc});
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
        idle_inputs();
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // concurrent-traffic vectors
    logic [63:0] ifv_addr [3] = '{64'h8000_0040, 64'h8000_0044, 64'h8000_0048};
    logic [63:0] ifv_exp  [3] = '{64'h13, 64'hFFFF_FFFF, 64'h89AB_CDEF};
    logic        lsv_we   [3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] lsv_addr [3] = '{64'h8000_0100, 64'h8000_0108, 64'h8000_0110};
    logic [63:0] lsv_wd   [3] = '{64'h0, 64'h1122_3344_5566_FF77, 64'h0};
    logic [1:0]  lsv_size [3] = '{2'b01, 2'b00, 2'b11};
    logic        lsv_sgn  [3] = '{1'b1, 1'b0, 1'b0};
    logic [63:0] lsv_exp  [3] = '{64'hFFFF_FFFF_FFFF_8001, 64'h0,
                                  64'hFEDC_BA98_7654_3210};

    initial begin
        int ii;
        int li;
        int last_acc;
        bit expect_ls;
        idle_inputs();
        rst = 1'b0;
        // reset with both masters requesting: nothing accepted, outputs zero
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        if_req_addr = 64'h8000_0000; ls_req_addr = 64'h8000_0008;
        wait_cycles(3);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;

        // signed word load
        issue(1'b1, 1'b0, 64'h8000_0008, 64'h0, 2'b10, 1'b1, 1'b1,
              64'hFFFF_FFFF_8000_0001, 64'h0, 8'h00);
        wait_cycles(3);
        // halfword store
        issue(1'b1, 1'b1, 64'h8000_0010, 64'hDEAD_BEEF_1234_ABCD, 2'b01, 1'b0, 1'b1,
              64'h0, 64'h0000_0000_0000_ABCD, 8'h03);
        wait_cycles(3);
        // fetch
        issue(1'b0, 1'b0, 64'h8000_0000, 64'h0, 2'b00, 1'b0, 1'b1,
              64'h0010_0513, 64'h0, 8'h00);
        wait_cycles(3);
        // unsigned byte load
        issue(1'b1, 1'b0, 64'h8000_0020, 64'h0, 2'b00, 1'b0, 1'b1,
              64'h0000_0000_0000_00F0, 64'h0, 8'h00);
        wait_cycles(3);

        // reset during RD: the load response must never appear
        issue(1'b1, 1'b0, 64'h8000_0008, 64'h0, 2'b10, 1'b1, 1'b0,
              64'h0, 64'h0, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("reset_mid_outputs");
        @(posedge clk); #1;
        rst = 1'b1;

        // both masters valid every cycle: LSU, IFU, LSU, ... 3 cycles apart
        ii = 0; li = 0; last_acc = -1; expect_ls = 1'b1;
        for (int c = 0; c < 60 && (ii < 3 || li < 3); c++) begin
            if_req_valid = (ii < 3);
            if (ii < 3) if_req_addr = ifv_addr[ii];
            ls_req_valid = (li < 3);
            if (li < 3) begin
                ls_req_we = lsv_we[li]; ls_req_addr = lsv_addr[li];
                ls_req_wdata = lsv_wd[li]; ls_req_size = lsv_size[li];
                ls_req_signed = lsv_sgn[li];
            end
            @(negedge clk);
            if (if_req_ready || ls_req_ready) begin
                check("grant_onehot", {62'h0, if_req_ready, ls_req_ready},
                      expect_ls ? 64'd1 : 64'd2);
                if (last_acc >= 0) check("accept_spacing", 64'(cyc - last_acc), 64'd3);
                last_acc = cyc;
                if (ls_req_ready && li < 3) begin
                    ls_q.push_back('{lsv_exp[li], cyc});
                    if (lsv_we[li])
                        wr_q.push_back('{lsv_addr[li], 64'h77, 8'h01, cyc});
                end
                if (if_req_ready && ii < 3) if_q.push_back('{ifv_exp[ii], cyc});
                @(posedge clk); #1;
                if (ls_req_ready_seen(expect_ls)) li++;
                else ii++;
                expect_ls = ~expect_ls;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("concurrent_done", 64'(ii + li), 64'd6);
        idle_inputs();
        wait_cycles(5);
        check("queues_drained", 64'(if_q.size() + ls_q.size() + wr_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // the port just accepted is the one the alternation expected (checked above)
    function automatic bit ls_req_ready_seen(input bit exp_ls);
        return exp_ls;
    endfunction

endmodule
